dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-write/single-read data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/loader).
//  Grants one access per cycle by round-robin; a requester may lock the memory for a burst of up to MAX_BURST beats.
//  Sits directly in front of DataMemory and routes its 1-cycle registered read data back to the requester that issued the read.
// PARAMETERS
//  MAX_BURST   8   max beats one locked burst may hold the grant (>=1)
//  RR_INIT     0   requester preferred first after reset (0 or 1)
//  WORD_SIZE, DMEM_ADDRW come from define.vh (`include "define.vh")
// PORTS
//  clk          in   1           clock, all state on posedge
//  rst          in   1           synchronous active-high reset
//  reqN_valid   in   1           (N=0,1) request present
//  reqN_ready   out  1           request accepted this cycle (valid&ready = beat)
//  reqN_we      in   1           1=write, 0=read
//  reqN_addr    in   DMEM_ADDRW  word address
//  reqN_wdata   in   WORD_SIZE   write data
//  reqN_lock    in   1           keep grant after this beat
//  rspN_valid   out  1           read data for requester N on rspN_rdata
//  rspN_rdata   out  WORD_SIZE   read data (valid only with rspN_valid)
//  mem_wen      out  1           to DataMemory wen
//  mem_waddr    out  DMEM_ADDRW  to DataMemory waddr
//  mem_wdata    out  WORD_SIZE   to DataMemory wdata
//  mem_raddr    out  DMEM_ADDRW  to DataMemory raddr
//  mem_rdata    in   WORD_SIZE   from DataMemory rdata
// BEHAVIOUR
//  - Reset: state=ARB, rr_ptr=RR_INIT, beat_cnt=0, rspN_valid=0; while rst=1 both reqN_ready=0 and mem_wen=0.
//  - reqN_ready combinational from state, rr_ptr, reqN_valid; never both 1; requesters must not wait for ready to assert valid.
//  - ARB: one valid -> grant it; both valid -> grant rr_ptr; none -> no grant. After any beat outside a lock, rr_ptr <= other requester.
//  - Granted write: mem_wen=1, mem_waddr/mem_wdata = granted addr/wdata, same cycle. No response.
//  - Granted read: mem_raddr=granted addr same cycle; rspN_valid=1 exactly one cycle later (register holds id), rspN_rdata=mem_rdata.
//    Latency 1 cycle, throughput 1 beat/cycle, reads fully pipelined across requesters.
//  - No grant: mem_wen=0, mem_raddr=0, no response next cycle.
//  - rspN_rdata = mem_rdata for both N (shared bus); only rspN_valid steers.
//  - Lock FSM states ARB, LOCK0, LOCK1:
//    ARB --beat by N with lock=1--> LOCKN, beat_cnt=1.
//    LOCKN: only N may get ready. Beat with lock=1 and beat_cnt<MAX_BURST-1: stay, beat_cnt++.
//    LOCKN --beat with lock=0--> ARB, rr_ptr=other. --beat reaching beat_cnt=MAX_BURST-1 (MAX_BURST-th beat)--> ARB, rr_ptr=other (forced release).
//    LOCKN --reqN_valid=0--> ARB next cycle, no grant that cycle, rr_ptr=other.
//    MAX_BURST=1: lock ignored, FSM never leaves ARB.
//  - Write then read of same address on consecutive beats returns the new data; same-cycle hazard impossible (one beat/cycle).
//  - Reset mid-burst or with a read in flight: lock dropped, pending rspN_valid suppressed (0 in cycle after rst).
//  - beat_cnt width = $clog2(MAX_BURST+1); no wrap possible because release at MAX_BURST.
// STRUCTURE
//  - define.vh gains: ARB_ST_ARB/ARB_ST_LOCK0/ARB_ST_LOCK1 state encodings, DMEM_MAX_BURST default constant.
//  - One sub-module: arb_rr2 (2-way round-robin grant: inputs req[1:0], ptr, mask; output one-hot gnt).
//  - Top holds FSM, rr_ptr, beat_cnt, response-id register; DataMemory instantiated by the parent, not here.
// TESTING
//  1 Reset: hold rst 2 cycles with both valid=1 -> ready0=ready1=0, mem_wen=0, rsp valids 0; first grant after release goes to RR_INIT.
//  2 Single write/read: req0 write addr 5 data 0xA5A5, next req0 read addr 5 -> mem_wen pulse, rsp0_valid 1 cycle after read, rdata 0xA5A5.
//  3 Contention: both read continuously, no lock -> grants alternate 0,1,0,1; rsp0/rsp1 alternate one cycle later, no lost beats.
//  4 Lock burst: req0 lock=1 for 3 beats then lock=0, req1 valid throughout -> 4 consecutive req0 beats, then req1 granted.
//  5 Forced release: MAX_BURST=8, req0 lock=1 held forever, req1 valid -> exactly 8 req0 beats, then 1 req1 beat, then req0 again.
//  6 Reset mid-operation: assert rst in cycle after a req1 read and in LOCK0 -> rsp1_valid=0 next cycle, state ARB, no grant during rst.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Word/address widths match the DataMemory instance behind it.
package dmem_arbiter_pkg;

   localparam int WORD_SIZE      = 32;
   localparam int DMEM_ADDRW     = 10;
   localparam int DMEM_MAX_BURST = 8;

   typedef enum logic [1:0] {
      ARB_ST_ARB   = 2'd0,
      ARB_ST_LOCK0 = 2'd1,
      ARB_ST_LOCK1 = 2'd2
   } arb_st_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// slave: the arbiter; master: requesters plus the DataMemory.
interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;

   logic                  req0_valid;
   logic                  req0_ready;
   logic                  req0_we;
   logic [DMEM_ADDRW-1:0] req0_addr;
   logic [WORD_SIZE-1:0]  req0_wdata;
   logic                  req0_lock;
   logic                  rsp0_valid;
   logic [WORD_SIZE-1:0]  rsp0_rdata;

   logic                  req1_valid;
   logic                  req1_ready;
   logic                  req1_we;
   logic [DMEM_ADDRW-1:0] req1_addr;
   logic [WORD_SIZE-1:0]  req1_wdata;
   logic                  req1_lock;
   logic                  rsp1_valid;
   logic [WORD_SIZE-1:0]  rsp1_rdata;

   logic                  mem_wen;
   logic [DMEM_ADDRW-1:0] mem_waddr;
   logic [WORD_SIZE-1:0]  mem_wdata;
   logic [DMEM_ADDRW-1:0] mem_raddr;
   logic [WORD_SIZE-1:0]  mem_rdata;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
      input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
      output req0_ready, rsp0_valid, rsp0_rdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output mem_wen, mem_waddr, mem_wdata, mem_raddr,
      input  mem_rdata
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
      output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  mem_wen, mem_waddr, mem_wdata, mem_raddr,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Two-way round-robin grant: masked requests, ptr breaks ties.
// Output is one-hot or zero.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);

   logic [1:0] eligible;

   assign eligible = req & mask;

   always_comb begin
      gnt = 2'b00;
      unique case (eligible)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst locking in front of DataMemory;
// steers the 1-cycle registered read data back to the issuing port.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = DMEM_MAX_BURST,
   parameter int RR_INIT   = 0
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   localparam int            CW   = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
   localparam bit            LOCK_OK = (MAX_BURST > 1);

   arb_st_t       state, state_n;
   logic          rr_ptr, rr_ptr_n;
   logic [CW-1:0] beat_cnt, beat_cnt_n;
   logic [1:0]    rsp_v, rsp_v_n;

   logic [1:0]            req, mask, gnt, grant;
   logic                  beat, g1, lock_g, we_g;
   logic [DMEM_ADDRW-1:0] addr_g;
   logic [WORD_SIZE-1:0]  wdata_g;

   assign req = {bus.req1_valid, bus.req0_valid};

   always_comb begin
      mask = 2'b11;
      unique case (state)
         ARB_ST_LOCK0: mask = 2'b01;
         ARB_ST_LOCK1: mask = 2'b10;
         default:      mask = 2'b11;
      endcase
   end

   arb_rr2 u_rr (
      .req  (req),
      .ptr  (rr_ptr),
      .mask (mask),
      .gnt  (gnt)
   );

   // Nothing is granted while reset is held
   assign grant   = rst ? 2'b00 : gnt;
   assign beat    = |grant;
   assign g1      = grant[1];
   assign lock_g  = g1 ? bus.req1_lock  : bus.req0_lock;
   assign we_g    = g1 ? bus.req1_we    : bus.req0_we;
   assign addr_g  = g1 ? bus.req1_addr  : bus.req0_addr;
   assign wdata_g = g1 ? bus.req1_wdata : bus.req0_wdata;

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.mem_wen    = beat & we_g;
   assign bus.mem_waddr  = beat ? addr_g : '0;
   assign bus.mem_wdata  = beat ? wdata_g : '0;
   assign bus.mem_raddr  = (beat & ~we_g) ? addr_g : '0;
   assign bus.rsp0_valid = rsp_v[0] & ~rst;
   assign bus.rsp1_valid = rsp_v[1] & ~rst;
   assign bus.rsp0_rdata = bus.mem_rdata;
   assign bus.rsp1_rdata = bus.mem_rdata;

   always_comb begin
      state_n    = state;
      rr_ptr_n   = rr_ptr;
      beat_cnt_n = beat_cnt;
      rsp_v_n    = grant & {~we_g, ~we_g};
      unique case (state)
         ARB_ST_ARB: begin
            if (beat) begin
               if (lock_g && LOCK_OK) begin
                  state_n    = g1 ? ARB_ST_LOCK1 : ARB_ST_LOCK0;
                  beat_cnt_n = CW'(1);
               end else begin
                  rr_ptr_n = ~g1;
               end
            end
         end
         default: begin
            if (!beat) begin
               state_n    = ARB_ST_ARB;
               rr_ptr_n   = (state == ARB_ST_LOCK0);
               beat_cnt_n = '0;
            end else if (lock_g && beat_cnt < LAST) begin
               beat_cnt_n = beat_cnt + CW'(1);
            end else begin
               state_n    = ARB_ST_ARB;
               rr_ptr_n   = ~g1;
               beat_cnt_n = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_ST_ARB;
         rr_ptr   <= 1'(RR_INIT);
         beat_cnt <= '0;
         rsp_v    <= 2'b00;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         beat_cnt <= beat_cnt_n;
         rsp_v    <= rsp_v_n;
      end
   end

endmodule
